// File: rtl/fft8_pkg.sv
// Shared sizes and FSM state type for the fft8 streaming controller.
package fft8_pkg;
    localparam int N_PTS = 8;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int IDX_W = $clog2(N_PTS);

    typedef enum logic [1:0] {
        COLLECT,
        START,
        WAIT,
        DRAIN
    } state_t;
endpackage

// File: rtl/fft8_frame_buf.sv
// Write-indexed sample register buffer; lane k holds sample k of the frame.
module fft8_frame_buf
    import fft8_pkg::*;
#(
    parameter int NUM_LANES = N_PTS,
    parameter int VEC_W     = IN_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [$clog2(NUM_LANES)-1:0]  wr_idx,
    input  logic [VEC_W-1:0]              wr_real,
    input  logic [VEC_W-1:0]              wr_imag,
    output logic [NUM_LANES*VEC_W-1:0]    x_real,
    output logic [NUM_LANES*VEC_W-1:0]    x_imag
);
    localparam int IW = $clog2(NUM_LANES);

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_r, lane_i;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_r[k] <= '0;
                lane_i[k] <= '0;
            end else if (we && wr_idx == IW'(k)) begin
                lane_r[k] <= wr_real;
                lane_i[k] <= wr_imag;
            end
        end
    end

    assign x_real = lane_r;
    assign x_imag = lane_i;
endmodule

// File: rtl/fft8_stream_ctrl.sv
// Streams 8 samples into an fft8 core, waits (bounded) for its result and
// drains the 8 bins out as a handshaked stream.
module fft8_stream_ctrl
    import fft8_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int FCW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_real,
    input  logic [IN_W-1:0]          in_imag,
    output logic                     core_start,
    output logic [N_PTS*IN_W-1:0]    core_x_real,
    output logic [N_PTS*IN_W-1:0]    core_x_imag,
    input  logic                     core_valid,
    input  logic [N_PTS*OUT_W-1:0]   core_X_real,
    input  logic [N_PTS*OUT_W-1:0]   core_X_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_real,
    output logic [OUT_W-1:0]         out_imag,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     err_timeout,
    input  logic                     err_clr,
    output logic [FCW-1:0]           frame_cnt
);
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                          state;
    logic [IDX_W-1:0]                wr_idx;
    logic [WCW-1:0]                  wait_cnt;
    logic [N_PTS-1:0][OUT_W-1:0]     res_r, res_i;
    logic                            in_acc, timeout_hit;

    assign in_ready    = (state == COLLECT);
    assign in_acc      = in_valid && in_ready;
    // core_valid has priority over an expiring wait counter
    assign timeout_hit = (state == WAIT) && !core_valid && (wait_cnt == WCW'(TIMEOUT - 1));

    fft8_frame_buf #(.NUM_LANES(N_PTS), .VEC_W(IN_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (in_acc),
        .wr_idx  (wr_idx),
        .wr_real (in_real),
        .wr_imag (in_imag),
        .x_real  (core_x_real),
        .x_imag  (core_x_imag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            wr_idx     <= '0;
            wait_cnt   <= '0;
            res_r      <= '0;
            res_i      <= '0;
            out_index  <= '0;
            frame_cnt  <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                COLLECT: if (in_acc) begin
                    wr_idx <= wr_idx + 1'b1;
                    if (wr_idx == IDX_W'(N_PTS - 1)) begin
                        state      <= START;
                        core_start <= 1'b1;
                    end
                end
                START: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (core_valid) begin
                        res_r <= core_X_real;
                        res_i <= core_X_imag;
                        state <= DRAIN;
                    end else if (timeout_hit) begin
                        state <= COLLECT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: if (out_ready) begin
                    out_index <= out_index + 1'b1;
                    if (out_index == IDX_W'(N_PTS - 1)) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           err_timeout <= 1'b0;
        else if (timeout_hit) err_timeout <= 1'b1;
        else if (err_clr)     err_timeout <= 1'b0;
    end

    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (out_index == IDX_W'(N_PTS - 1));
    assign out_real  = out_valid ? res_r[out_index] : '0;
    assign out_imag  = out_valid ? res_i[out_index] : '0;
endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Self-checking bench: directed frame table, random frames, timeout and reset corners.
module tb_fft8_stream_ctrl;
    localparam int TO  = 16;
    localparam int FCW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready;
    logic [15:0]  in_real, in_imag;
    logic         core_start;
    logic [127:0] core_x_real, core_x_imag;
    logic         core_valid, core_valid_m, spur;
    logic [255:0] core_X_real, core_X_imag;
    logic         out_valid, out_ready;
    logic [31:0]  out_real, out_imag;
    logic [2:0]   out_index;
    logic         out_last, err_timeout, err_clr;
    logic [FCW-1:0] frame_cnt;

    assign core_valid = core_valid_m | spur;

    fft8_stream_ctrl #(.TIMEOUT(TO), .FCW(FCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .core_start(core_start), .core_x_real(core_x_real), .core_x_imag(core_x_imag),
        .core_valid(core_valid), .core_X_real(core_X_real), .core_X_imag(core_X_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last),
        .err_timeout(err_timeout), .err_clr(err_clr), .frame_cnt(frame_cnt)
    );

    int checks = 0, failures = 0;
    int exp_fc = 0, exp_starts = 0, n_starts = 0;
    int core_delay = 5;
    bit core_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference 8-point DFT, rounded to Q16.16
    task automatic dft(input int xr[8], input int xi[8], output logic [31:0] yr[8], output logic [31:0] yi[8]);
        for (int k = 0; k < 8; k++) begin
            real sr, si, a;
            sr = 0.0; si = 0.0;
            for (int n = 0; n < 8; n++) begin
                a  = 2.0 * 3.14159265358979 * k * n / 8.0;
                sr = sr + xr[n] * $cos(a) + xi[n] * $sin(a);
                si = si + xi[n] * $cos(a) - xr[n] * $sin(a);
            end
            yr[k] = 32'($rtoi(sr * 65536.0 + ((sr >= 0.0) ? 0.5 : -0.5)));
            yi[k] = 32'($rtoi(si * 65536.0 + ((si >= 0.0) ? 0.5 : -0.5)));
        end
    endtask

    // fft8 core model: answers core_delay cycles after each start pulse
    initial begin
        int cd;
        int xr[8], xi[8];
        logic [31:0] yr[8], yi[8];
        logic [255:0] pr, pi;
        cd = 0; pr = '0; pi = '0;
        core_valid_m = 1'b0; core_X_real = '0; core_X_imag = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                n_starts++;
                if (core_en) begin
                    for (int n = 0; n < 8; n++) begin
                        xr[n] = int'($signed(core_x_real[16*n +: 16]));
                        xi[n] = int'($signed(core_x_imag[16*n +: 16]));
                    end
                    dft(xr, xi, yr, yi);
                    for (int k = 0; k < 8; k++) begin
                        pr[32*k +: 32] = yr[k];
                        pi[32*k +: 32] = yi[k];
                    end
                    cd = core_delay;
                end
            end
            @(posedge clk); #1;
            core_valid_m = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_valid_m = 1'b1;
                    core_X_real  = pr;
                    core_X_imag  = pi;
                end
            end
        end
    end

    task automatic push(input int r, input int i, input int gap, input bit spur_en);
        bit acc;
        int t;
        repeat (gap) begin
            in_valid = 1'b0;
            spur = spur_en ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            chk("no_out_in_collect", out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_real = 16'(r); in_imag = 16'(i);
        t = 0; acc = 1'b0;
        do begin
            spur = spur_en ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 300);
        if (!acc) chk("push_bound", 0, 1);
        in_valid = 1'b0; spur = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0][15:0] pr, input logic [7:0][15:0] pi, input bit gaps, input bit spur_en);
        for (int n = 0; n < 8; n++)
            push(int'($signed(pr[n])), int'($signed(pi[n])), gaps ? int'($urandom_range(0, 3)) : 0, spur_en);
    endtask

    task automatic drain(input logic [31:0] er[8], input logic [31:0] ei[8], input bit stall, input int lat);
        int beat, t, first_t;
        bit stalled;
        logic [31:0] sr, si;
        logic [2:0] sx;
        beat = 0; t = 0; first_t = -1; stalled = 1'b0; sr = '0; si = '0; sx = '0;
        while (beat < 8 && t < 400) begin
            out_ready = stall ? ($urandom % 3 != 0) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (first_t < 0) begin
                    first_t = t;
                    chk("first_out_latency", t, lat);
                end
                if (stalled) begin
                    chk("stall_real", out_real, sr);
                    chk("stall_imag", out_imag, si);
                    chk("stall_index", out_index, sx);
                end
                chk("out_index", out_index, beat);
                chk("out_real", out_real, er[beat]);
                chk("out_imag", out_imag, ei[beat]);
                chk("out_last", out_last, beat == 7);
                chk("in_ready_drain", in_ready, 0);
                stalled = !out_ready; sr = out_real; si = out_imag; sx = out_index;
                if (out_ready) beat++;
            end
            @(posedge clk); #1;
            t++;
        end
        if (beat < 8) chk("drain_bound", beat, 8);
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("out_index_after", out_index, 0);
        chk("frame_cnt", frame_cnt, exp_fc);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [7:0][15:0] pr, input logic [7:0][15:0] pi, input bit gaps, input bit stall,
                             input bit spur_en, input bit use_e0, input logic [31:0] e0r, input logic [31:0] e0i);
        int xr[8], xi[8];
        logic [31:0] er[8], ei[8];
        for (int n = 0; n < 8; n++) begin
            xr[n] = int'($signed(pr[n]));
            xi[n] = int'($signed(pi[n]));
        end
        dft(xr, xi, er, ei);
        if (use_e0) begin er[0] = e0r; ei[0] = e0i; end
        send_frame(pr, pi, gaps, spur_en);
        exp_fc++; exp_starts++;
        drain(er, ei, stall, core_delay + 1);
        chk("start_pulses", n_starts, exp_starts);
        chk("core_x_hold", (core_x_real == pr) && (core_x_imag == pi), 1);
    endtask

    // Counts cycles from the START cycle until err_timeout is seen
    task automatic wait_timeout(output int got, output bit saw_out);
        got = -1; saw_out = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) saw_out = 1'b1;
            if (err_timeout) begin got = c; break; end
            @(posedge clk); #1;
        end
    endtask

    typedef struct packed {
        logic [7:0][15:0] xr;
        logic [7:0][15:0] xi;
        logic             gaps;
        logic             stall;
        logic [31:0]      exp_re0;
        logic [31:0]      exp_im0;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [7:0][15:0] rr, ri;
        int got;
        bit saw;

        rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
        out_ready = 1'b0; err_clr = 1'b0; spur = 1'b0;

        for (int n = 0; n < 8; n++) begin
            vt[0].xr[n] = 16'(n + 1);             vt[0].xi[n] = '0;
            vt[1].xr[n] = (n == 0) ? 16'd100 : '0; vt[1].xi[n] = (n == 7) ? 16'd50 : '0;
            vt[2].xr[n] = (n % 2 == 0) ? 16'd4000 : 16'(-4001); vt[2].xi[n] = 16'(n + 1);
            vt[3].xr[n] = '0;                     vt[3].xi[n] = '0;
        end
        vt[0].gaps = 0; vt[0].stall = 0; vt[0].exp_re0 = 32'd2359296;   vt[0].exp_im0 = 32'd0;
        vt[1].gaps = 0; vt[1].stall = 1; vt[1].exp_re0 = 32'd6553600;   vt[1].exp_im0 = 32'd3276800;
        vt[2].gaps = 1; vt[2].stall = 1; vt[2].exp_re0 = 32'(-262144);  vt[2].exp_im0 = 32'd2359296;
        vt[3].gaps = 0; vt[3].stall = 0; vt[3].exp_re0 = 32'd0;         vt[3].exp_im0 = 32'd0;

        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_core_x", core_x_real == '0 && core_x_imag == '0, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed frame table; frame 2 also has input gaps and spurious core_valid
        for (int v = 0; v < 4; v++)
            run_frame(vt[v].xr, vt[v].xi, vt[v].gaps, vt[v].stall, vt[v].gaps, 1'b1, vt[v].exp_re0, vt[v].exp_im0);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 8; n++) begin
                rr[n] = 16'(int'($urandom_range(0, 4000)) - 2000);
                ri[n] = 16'(int'($urandom_range(0, 4000)) - 2000);
            end
            run_frame(rr, ri, 1'($urandom % 2), 1'b1, 1'($urandom % 2), 1'b0, '0, '0);
        end

        // core_valid on the last allowed WAIT cycle still wins over the timeout
        core_delay = TO;
        run_frame(vt[0].xr, vt[0].xi, 1'b0, 1'b0, 1'b0, 1'b1, vt[0].exp_re0, vt[0].exp_im0);
        chk("valid_beats_timeout", err_timeout, 0);
        core_delay = 5;

        // Timeout: core never answers
        core_en = 1'b0;
        send_frame(vt[1].xr, vt[1].xi, 1'b0, 1'b0);
        exp_starts++;
        wait_timeout(got, saw);
        chk("timeout_cycle", got, TO + 1);
        chk("timeout_no_out", saw, 0);
        chk("timeout_in_ready", in_ready, 1);
        chk("timeout_frame_cnt", frame_cnt, exp_fc);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", err_timeout, 0);
        @(posedge clk); #1;

        // Timeout with err_clr held: set wins, clear follows
        err_clr = 1'b1;
        send_frame(vt[1].xr, vt[1].xi, 1'b0, 1'b0);
        exp_starts++;
        wait_timeout(got, saw);
        chk("set_wins_cycle", got, TO + 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_after_set", err_timeout, 0);
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("start_pulses_to", n_starts, exp_starts);
        core_en = 1'b1;

        // Reset in DRAIN at out_index 3
        send_frame(vt[0].xr, vt[0].xi, 1'b0, 1'b0);
        exp_starts++;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid && out_index == 3'd3) begin got = 1; break; end
            @(posedge clk); #1;
        end
        chk("reached_index3", got, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_out_data", {out_real, out_imag}, 0);
        chk("mid_rst_out_index", out_index, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_core_x", core_x_real == '0 && core_x_imag == '0, 1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_fc = 0;
        @(posedge clk); #1;
        run_frame(vt[0].xr, vt[0].xi, 1'b0, 1'b1, 1'b0, 1'b1, vt[0].exp_re0, vt[0].exp_im0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
